filterbank_taps_sender: RTL and testbench

Message source that drives a filterbank's `in_msg`/`in_msg_nd` port to set taps. It buffers one filter's worth of taps loaded from a local stream. On command it emits a single tap-setting message: a header word followed by the taps, one word per cycle. It sits upstream of `filterbank` in the message chain, alongside other message producers.

---
 rtl/filterbank_taps_sender_pkg.sv | 29 ++
 rtl/filterbank_taps_sender_tap_buffer.sv | 34 +++
 rtl/filterbank_taps_sender.sv | 158 +++++++++++++++
 tb/tb_filterbank_taps_sender.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/filterbank_taps_sender_pkg.sv
// ----------------------------------------------------------------------------
// filterbank_taps_sender_pkg : shared message word layout and sender states
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package filterbank_taps_sender_pkg;

  localparam int c_MSG_WIDTH = 32;
  localparam int c_LEN_WIDTH = 8;
  localparam int c_ID_WIDTH  = 8;
  localparam int c_FILT_LSB  = 8;
  localparam int c_DEST_LSB  = 0;

  localparam logic [0:0] c_ST_LOAD = 1'b0;
  localparam logic [0:0] c_ST_SEND = 1'b1;

  // The flag sits at the MSB and the length field lies directly beneath it.
  function automatic int hdr_flag_pos(input int msg_width);
    return msg_width - 1;
  endfunction

  function automatic int hdr_len_lsb(input int msg_width);
    return msg_width - 1 - c_LEN_WIDTH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filterbank_taps_sender_tap_buffer.sv
// ----------------------------------------------------------------------------
// filterbank_taps_sender_tap_buffer : one-write/one-read tap store, 1-cycle read
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module filterbank_taps_sender_tap_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/filterbank_taps_sender.sv
// ----------------------------------------------------------------------------
// filterbank_taps_sender : buffers one filter's taps and emits a tap-set message
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module filterbank_taps_sender
  import filterbank_taps_sender_pkg::*;
#(
  parameter int MSG_WIDTH     = c_MSG_WIDTH,
  parameter int TAP_WIDTH     = 16,
  parameter int FILTER_LENGTH = 4,
  parameter int N_FILTERS     = 2,
  parameter int DEST_ID       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TAP_WIDTH-1:0] in_tap,
  input  logic                 in_tap_nd,
  input  logic [7:0]           in_filter,
  input  logic                 in_send,
  output logic [MSG_WIDTH-1:0] out_msg,
  output logic                 out_msg_nd,
  output logic                 busy,
  output logic                 error
);

  localparam int c_CW       = $clog2(FILTER_LENGTH + 1);
  localparam int c_AW       = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
  localparam int c_FLAG_POS = hdr_flag_pos(MSG_WIDTH);
  localparam int c_LEN_LSB  = hdr_len_lsb(MSG_WIDTH);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FILTER_LENGTH);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [c_CW-1:0]       r_count;
  logic [c_CW-1:0]       r_word;
  logic [c_ID_WIDTH-1:0] r_filter;
  logic [MSG_WIDTH-1:0]  r_out_msg;
  logic                  r_out_nd;
  logic                  r_busy;
  logic                  r_error;

  logic                  w_full;
  logic                  w_idx_ok;
  logic                  w_send_ok;
  logic                  w_last;
  logic                  w_wr_en;
  logic                  w_err_evt;
  logic [c_AW-1:0]       w_rd_addr;
  logic [TAP_WIDTH-1:0]  w_rd_data;
  logic [MSG_WIDTH-1:0]  w_header;
  logic [MSG_WIDTH-1:0]  w_msg_nxt;
  logic                  w_nd_nxt;

  // Send eligibility uses the count before any write landing this cycle.
  assign w_full    = (r_count == c_FULL);
  assign w_idx_ok  = ({1'b0, in_filter} < 9'(N_FILTERS));
  assign w_send_ok = in_send && w_full && w_idx_ok;
  assign w_last    = (r_word == c_FULL);

  always_comb begin
    w_header = '0;
    w_header[c_FLAG_POS]                           = 1'b1;
    w_header[c_LEN_LSB +: c_LEN_WIDTH]             = c_LEN_WIDTH'(FILTER_LENGTH);
    w_header[c_FILT_LSB +: c_ID_WIDTH]             = r_filter;
    w_header[c_DEST_LSB +: c_ID_WIDTH]             = c_ID_WIDTH'(DEST_ID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_LOAD: if (w_send_ok) w_state_nxt = c_ST_SEND;
      c_ST_SEND: if (w_last)    w_state_nxt = c_ST_LOAD;
      default:                  w_state_nxt = c_ST_LOAD;
    endcase
  end

  // r_word 0 is the header cycle; it also launches the tap-0 read so each
  // payload cycle forwards the word fetched on the previous edge.
  always_comb begin
    w_wr_en   = 1'b0;
    w_err_evt = 1'b0;
    w_rd_addr = '0;
    w_msg_nxt = r_out_msg;
    w_nd_nxt  = 1'b0;
    case (r_state)
      c_ST_LOAD: begin
        w_wr_en   = in_tap_nd && !w_full;
        w_err_evt = (in_tap_nd && w_full) || (in_send && !w_send_ok);
      end
      c_ST_SEND: begin
        w_err_evt = in_tap_nd || in_send;
        w_nd_nxt  = 1'b1;
        w_msg_nxt = (r_word == '0) ? w_header : MSG_WIDTH'(w_rd_data);
        if (!w_last) begin
          w_rd_addr = c_AW'(r_word);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_word    <= '0;
      r_filter  <= '0;
      r_out_msg <= '0;
      r_out_nd  <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (r_state == c_ST_SEND && w_last) begin
        r_count <= '0;
      end else if (w_wr_en) begin
        r_count <= r_count + c_CW'(1);
      end
      r_word <= (r_state == c_ST_SEND && !w_last) ? r_word + c_CW'(1) : '0;
      if (r_state == c_ST_LOAD && w_send_ok) begin
        r_filter <= in_filter;
      end
      r_out_msg <= w_msg_nxt;
      r_out_nd  <= w_nd_nxt;
      r_busy    <= w_nd_nxt;
      r_error   <= r_error | w_err_evt;
    end
  end

  filterbank_taps_sender_tap_buffer #(
    .DEPTH      (FILTER_LENGTH),
    .DATA_WIDTH (TAP_WIDTH),
    .ADDR_WIDTH (c_AW)
  ) u_tap_buffer (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (c_AW'(r_count)),
    .wr_data (in_tap),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  assign out_msg    = r_out_msg;
  assign out_msg_nd = r_out_nd;
  assign busy       = r_busy;
  assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_filterbank_taps_sender.sv
// ----------------------------------------------------------------------------
// tb_filterbank_taps_sender : directed self-checking bench for the taps sender
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_filterbank_taps_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_tap = '0;
  logic        in_tap_nd = 1'b0;
  logic [7:0]  in_filter = '0;
  logic        in_send = 1'b0;
  logic [31:0] out_msg;
  logic        out_msg_nd;
  logic        busy;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  filterbank_taps_sender #(
    .MSG_WIDTH     (32),
    .TAP_WIDTH     (16),
    .FILTER_LENGTH (4),
    .N_FILTERS     (2),
    .DEST_ID       (3)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tap     (in_tap),
    .in_tap_nd  (in_tap_nd),
    .in_filter  (in_filter),
    .in_send    (in_send),
    .out_msg    (out_msg),
    .out_msg_nd (out_msg_nd),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_tap_nd = 1'b0;
    in_send   = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_tap(input logic [15:0] v);
    in_tap    = v;
    in_tap_nd = 1'b1;
    tick();
    in_tap_nd = 1'b0;
  endtask

  task automatic send(input logic [7:0] f);
    in_filter = f;
    in_send   = 1'b1;
    tick();
    in_send = 1'b0;
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq({tag, "_nd"}, {31'd0, out_msg_nd}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  // Called right after the accepting edge; header appears one edge later.
  task automatic expect_msg(input string tag, input logic [31:0] hdr,
                            input logic [15:0] t0, input logic [15:0] t1,
                            input logic [15:0] t2, input logic [15:0] t3);
    logic [31:0] words [5];
    words[0] = hdr;
    words[1] = {16'd0, t0};
    words[2] = {16'd0, t1};
    words[3] = {16'd0, t2};
    words[4] = {16'd0, t3};
    check_eq({tag, "_pre_nd"}, {31'd0, out_msg_nd}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("%s_w%0d", tag, k), out_msg, words[k]);
      check_eq($sformatf("%s_nd%0d", tag, k), {31'd0, out_msg_nd}, 32'd1);
      check_eq($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin
    #2;
    check_eq("rst_msg", out_msg, 32'd0);
    check_eq("rst_nd", {31'd0, out_msg_nd}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, error}, 32'd0);
    do_reset();

    // Basic send
    load_tap(16'h0001); load_tap(16'h0002); load_tap(16'hFFFF); load_tap(16'h8000);
    send(8'd1);
    expect_msg("basic", 32'h82000103, 16'h0001, 16'h0002, 16'hFFFF, 16'h8000);
    expect_idle("basic_after", 1);
    check_eq("basic_hold", out_msg, 32'h00008000);
    check_eq("basic_err", {31'd0, error}, 32'd0);

    // Early send, then send coinciding with the final tap, then a valid send
    do_reset();
    load_tap(16'h0011); load_tap(16'h0022); load_tap(16'h0033);
    send(8'd0);
    expect_idle("early", 2);
    check_eq("early_err", {31'd0, error}, 32'd1);
    in_filter = 8'd0;
    in_send   = 1'b1;
    load_tap(16'h0044);
    in_send = 1'b0;
    expect_idle("final_tap_send", 2);
    send(8'd0);
    expect_msg("early_ok", 32'h82000003, 16'h0011, 16'h0022, 16'h0033, 16'h0044);

    // Bad filter index keeps the buffer
    do_reset();
    load_tap(16'h000A); load_tap(16'h000B); load_tap(16'h000C); load_tap(16'h000D);
    send(8'd2);
    expect_idle("badidx", 2);
    check_eq("badidx_err", {31'd0, error}, 32'd1);
    send(8'd1);
    expect_msg("badidx_ok", 32'h82000103, 16'h000A, 16'h000B, 16'h000C, 16'h000D);

    // Overflow and send overlapping a tap
    do_reset();
    load_tap(16'h0100); load_tap(16'h0101); load_tap(16'h0102); load_tap(16'h0103);
    check_eq("ovf_err0", {31'd0, error}, 32'd0);
    load_tap(16'h0999);
    check_eq("ovf_err1", {31'd0, error}, 32'd1);
    in_tap    = 16'h0777;
    in_tap_nd = 1'b1;
    send(8'd0);
    in_tap_nd = 1'b0;
    expect_msg("overlap", 32'h82000003, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
    check_eq("overlap_err", {31'd0, error}, 32'd1);

    // Back-to-back: reload begins the cycle after the last payload word
    do_reset();
    load_tap(16'h1111); load_tap(16'h2222); load_tap(16'h3333); load_tap(16'h4444);
    send(8'd1);
    expect_msg("b2b_a", 32'h82000103, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    load_tap(16'h5555);
    check_eq("b2b_gap_nd", {31'd0, out_msg_nd}, 32'd0);
    check_eq("b2b_gap_hold", out_msg, 32'h00004444);
    load_tap(16'h6666); load_tap(16'h7777); load_tap(16'h8888);
    send(8'd0);
    expect_msg("b2b_b", 32'h82000003, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    check_eq("b2b_err", {31'd0, error}, 32'd0);

    // Reset during payload word 1
    do_reset();
    load_tap(16'h0AAA); load_tap(16'h0BBB); load_tap(16'h0CCC); load_tap(16'h0DDD);
    send(8'd1);
    tick();
    check_eq("rmid_hdr", out_msg, 32'h82000103);
    tick();
    tick();
    check_eq("rmid_w1", out_msg, 32'h00000BBB);
    rst_n = 1'b0;
    #1;
    check_eq("rmid_nd", {31'd0, out_msg_nd}, 32'd0);
    check_eq("rmid_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'd1);
    expect_idle("rmid_after", 3);
    check_eq("rmid_err", {31'd0, error}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
